// File: rtl/bp_cfg_loader.sv
// bp_cfg_loader: post-reset cfg sequencer (freeze, core id, CCE ucode, mode, unfreeze per core);
// define BP_CFG_LOADER_READBACK_EN to read back FREEZE/CORE_ID/MODE writes and flag mismatches on err_o.
module bp_cfg_loader #(
    parameter int num_core_p        = 1,
    parameter int cfg_core_width_p  = 8,
    parameter int cfg_addr_width_p  = 16,
    parameter int cfg_data_width_p  = 64,
    parameter int cce_pc_width_p    = 8,
    parameter int cce_instr_width_p = 48,
    parameter int cce_mode_p        = 1
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    output logic                         cfg_v_o,
    output logic                         cfg_w_o,
    output logic [cfg_core_width_p-1:0]  cfg_core_o,
    output logic [cfg_addr_width_p-1:0]  cfg_addr_o,
    output logic [cfg_data_width_p-1:0]  cfg_data_o,
    input  logic                         cfg_ready_i,
    output logic [cce_pc_width_p-1:0]    ucode_addr_o,
    input  logic [cce_instr_width_p-1:0] ucode_data_i,
    output logic                         busy_o,
    output logic                         done_o,
    input  logic                         cfg_rdata_v_i,
    input  logic [cfg_data_width_p-1:0]  cfg_rdata_i,
    output logic                         err_o
);
    localparam int core_w_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;
    localparam logic [cfg_addr_width_p-1:0] uc_base_lp = cfg_addr_width_p'(32'h8000);
    typedef enum logic [3:0] {
        S_RESET, S_FREEZE, S_CORE_ID, S_UC_FETCH, S_UC_SEND,
        S_MODE, S_UNFREEZE, S_NEXT, S_DONE, S_RD_REQ, S_RD_WAIT
    } state_e;
    state_e state_q, state_n, vs, succ;
    logic [core_w_lp-1:0]        core_q, core_n;
    logic [cce_pc_width_p-1:0]   idx_q, idx_n;
    logic [cfg_data_width_p-1:0] uc_q, uc_n;
    logic [cfg_addr_width_p-1:0] wr_addr;
    logic [cfg_data_width_p-1:0] wr_data;
`ifdef BP_CFG_LOADER_READBACK_EN
    state_e rb_q, rb_n;
    logic   err_q, err_n;
    // While reading back, address/data/successor are those of the write being checked
    assign vs    = (state_q == S_RD_REQ || state_q == S_RD_WAIT) ? rb_q : state_q;
    assign err_o = err_q;
`else
    logic unused_rb;
    assign vs        = state_q;
    assign err_o     = 1'b0;
    assign unused_rb = ^{cfg_rdata_v_i, cfg_rdata_i};
`endif
    assign ucode_addr_o = idx_q;
    assign busy_o       = (state_q != S_RESET) && (state_q != S_DONE);
    assign done_o       = (state_q == S_DONE);
    always_comb begin
        wr_addr = (vs == S_UC_SEND) ? (uc_base_lp | cfg_addr_width_p'(idx_q))
                : (vs == S_CORE_ID) ? cfg_addr_width_p'(1)
                : (vs == S_MODE)    ? cfg_addr_width_p'(2) : '0;
        wr_data = (vs == S_UC_SEND) ? uc_q
                : (vs == S_FREEZE)  ? cfg_data_width_p'(1)
                : (vs == S_CORE_ID) ? cfg_data_width_p'(core_q)
                : (vs == S_MODE)    ? cfg_data_width_p'(cce_mode_p) : '0;
        succ    = (vs == S_FREEZE)  ? S_CORE_ID
                : (vs == S_CORE_ID) ? S_UC_FETCH
                : (vs == S_MODE)    ? S_UNFREEZE : S_NEXT;
    end
    always_comb begin
        state_n = state_q;
        core_n  = core_q;
        idx_n   = idx_q;
        uc_n    = uc_q;
`ifdef BP_CFG_LOADER_READBACK_EN
        rb_n    = rb_q;
        err_n   = err_q;
`endif
        cfg_v_o = 1'b0;
        cfg_w_o = 1'b0;
        case (state_q)
            S_RESET: state_n = S_FREEZE;
            S_FREEZE, S_CORE_ID, S_MODE, S_UNFREEZE: begin
                cfg_v_o = 1'b1;
                cfg_w_o = 1'b1;
`ifdef BP_CFG_LOADER_READBACK_EN
                rb_n    = cfg_ready_i ? state_q : rb_q;
                state_n = !cfg_ready_i ? state_q : (state_q == S_UNFREEZE) ? S_NEXT : S_RD_REQ;
`else
                state_n = cfg_ready_i ? succ : state_q;
`endif
            end
            S_UC_FETCH: begin
                uc_n    = cfg_data_width_p'(ucode_data_i);
                state_n = S_UC_SEND;
            end
            S_UC_SEND: begin
                cfg_v_o = 1'b1;
                cfg_w_o = 1'b1;
                idx_n   = cfg_ready_i ? idx_q + cce_pc_width_p'(1) : idx_q;
                state_n = !cfg_ready_i ? state_q : (&idx_q) ? S_MODE : S_UC_FETCH;
            end
            S_NEXT: begin
                core_n  = (core_q == core_w_lp'(num_core_p - 1)) ? core_q : core_q + core_w_lp'(1);
                state_n = (core_q == core_w_lp'(num_core_p - 1)) ? S_DONE : S_FREEZE;
            end
            S_DONE: state_n = S_DONE;
`ifdef BP_CFG_LOADER_READBACK_EN
            S_RD_REQ: begin
                cfg_v_o = 1'b1;
                state_n = cfg_ready_i ? S_RD_WAIT : state_q;
            end
            S_RD_WAIT: begin
                err_n   = err_q | (cfg_rdata_v_i && (cfg_rdata_i != wr_data));
                state_n = cfg_rdata_v_i ? succ : state_q;
            end
`endif
            default: state_n = S_RESET;
        endcase
        cfg_core_o = cfg_v_o ? cfg_core_width_p'(core_q) : '0;
        cfg_addr_o = cfg_v_o ? wr_addr : '0;
        cfg_data_o = (cfg_v_o && cfg_w_o) ? wr_data : '0;
    end
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= S_RESET;
            core_q  <= '0;
            idx_q   <= '0;
            uc_q    <= '0;
        end else begin
            state_q <= state_n;
            core_q  <= core_n;
            idx_q   <= idx_n;
            uc_q    <= uc_n;
        end
    end
`ifdef BP_CFG_LOADER_READBACK_EN
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rb_q  <= S_RESET;
            err_q <= 1'b0;
        end else begin
            rb_q  <= rb_n;
            err_q <= err_n;
        end
    end
`endif
endmodule

// File: tb/tb_bp_cfg_loader.sv
// tb_bp_cfg_loader: directed checks of bp_cfg_loader on a 1-core and a 4-core instance (pc width 2).
module tb_bp_cfg_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int checks = 0;
    int failures = 0;
    logic        a_rst_n, a_ready, a_v, a_w, a_busy, a_done, a_err, a_rdv;
    logic [7:0]  a_core;
    logic [15:0] a_addr;
    logic [63:0] a_data, a_rdata;
    logic [1:0]  a_ua;
    logic [47:0] a_ud;
    logic        b_rst_n, b_ready, b_v, b_w, b_busy, b_done, b_err, b_rdv;
    logic [7:0]  b_core;
    logic [15:0] b_addr;
    logic [63:0] b_data, b_rdata;
    logic [1:0]  b_ua;
    logic [47:0] b_ud;

    function automatic logic [47:0] rom(input logic [1:0] a);
        return 48'hC0DE_0000_1000 + 48'(a) * 48'h0000_0101_0001;
    endfunction
    assign a_ud = rom(a_ua);
    assign b_ud = rom(b_ua);

    bp_cfg_loader #(.num_core_p(1), .cce_pc_width_p(2)) u1 (
        .clk_i(clk), .reset_n_i(a_rst_n), .cfg_v_o(a_v), .cfg_w_o(a_w), .cfg_core_o(a_core),
        .cfg_addr_o(a_addr), .cfg_data_o(a_data), .cfg_ready_i(a_ready), .ucode_addr_o(a_ua),
        .ucode_data_i(a_ud), .busy_o(a_busy), .done_o(a_done), .cfg_rdata_v_i(a_rdv),
        .cfg_rdata_i(a_rdata), .err_o(a_err));
    bp_cfg_loader #(.num_core_p(4), .cce_pc_width_p(2)) u4 (
        .clk_i(clk), .reset_n_i(b_rst_n), .cfg_v_o(b_v), .cfg_w_o(b_w), .cfg_core_o(b_core),
        .cfg_addr_o(b_addr), .cfg_data_o(b_data), .cfg_ready_i(b_ready), .ucode_addr_o(b_ua),
        .ucode_data_i(b_ud), .busy_o(b_busy), .done_o(b_done), .cfg_rdata_v_i(b_rdv),
        .cfg_rdata_i(b_rdata), .err_o(b_err));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // k-th write of a core: FREEZE, CORE_ID, 4 ucode words, MODE, UNFREEZE
    task automatic chk_pkt(input string tag, input int c, input int k, input logic w,
                           input logic [7:0] core, input logic [15:0] addr, input logic [63:0] data);
        logic [15:0] ea;
        logic [63:0] ed;
        ea = (k == 0 || k == 7) ? 16'h0000 : (k == 1) ? 16'h0001 : (k == 6) ? 16'h0002
           : 16'h8000 + 16'(k - 2);
        ed = (k == 0 || k == 6) ? 64'd1 : (k == 1) ? 64'(c) : (k == 7) ? 64'd0
           : {16'd0, rom(2'(k - 2))};
        chk({tag, "_w"}, 64'(w), 64'd1);
        chk({tag, "_core"}, 64'(core), 64'(c));
        chk({tag, "_addr"}, 64'(addr), 64'(ea));
        chk({tag, "_data"}, data, ed);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_ready = 1'b1; b_ready = 1'b0;
        a_rdv = 1'b1; b_rdv = 1'b1;
        a_rdata = '0; b_rdata = '0;
        repeat (3) tick();
        chk("rst_v", 64'(a_v), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_done", 64'(a_done), 64'd0);
        chk("rst_err", 64'(a_err), 64'd0);
        chk("rst_addr", 64'(a_addr), 64'd0);
        chk("rst_ua", 64'(a_ua), 64'd0);
        chk("rst_b_v", 64'(b_v), 64'd0);
        a_rst_n = 1'b1;
        n = 0;
`ifdef BP_CFG_LOADER_READBACK_EN
        // CORE_ID readback answers 5 instead of the written 0
        for (int cyc = 1; cyc <= 200 && !a_done; cyc++) begin
            tick();
            if (a_v && a_w) begin
                chk_pkt("t5_pkt", 0, n, a_w, a_core, a_addr, a_data);
                a_rdata = (a_addr == 16'h0001) ? 64'd5 : a_data;
                n++;
            end
        end
        chk("t5_done", 64'(a_done), 64'd1);
        chk("t5_count", 64'(n), 64'd8);
        chk("t5_err", 64'(a_err), 64'd1);
        repeat (3) tick();
        chk("t5_err_sticky", 64'(a_err), 64'd1);
        chk("t5_done_hold", 64'(a_done), 64'd1);
`else
        for (int cyc = 1; cyc <= 14; cyc++) begin
            tick();
            if (a_v) begin
                chk_pkt("t1_pkt", 0, n, a_w, a_core, a_addr, a_data);
                a_rdata = (a_addr == 16'h0001) ? 64'd5 : a_data;
                n++;
            end
            if (cyc == 3) chk("t1_ua0", 64'(a_ua), 64'd0);
            if (cyc == 5) chk("t1_ua1", 64'(a_ua), 64'd1);
            if (cyc == 13) begin
                chk("t1_done13", 64'(a_done), 64'd0);
                chk("t1_busy13", 64'(a_busy), 64'd1);
            end
        end
        chk("t1_count", 64'(n), 64'd8);
        chk("t1_done14", 64'(a_done), 64'd1);
        chk("t1_busy14", 64'(a_busy), 64'd0);
        tick();
        tick();
        chk("t1_done_hold", 64'(a_done), 64'd1);
        chk("t1_v_idle", 64'(a_v), 64'd0);
        chk("t1_err", 64'(a_err), 64'd0);
        a_rst_n = 1'b0;
        tick();
        chk("t2_rst_done", 64'(a_done), 64'd0);
        a_rst_n = 1'b1;
        tick();
        chk("t2_freeze_addr", 64'(a_addr), 64'd0);
        tick();
        chk("t2_core_id_addr", 64'(a_addr), 64'd1);
        a_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_v", 64'(a_v), 64'd1);
            chk("t2_hold_addr", 64'(a_addr), 64'd1);
            chk("t2_hold_data", a_data, 64'd0);
        end
        a_ready = 1'b1;
        tick();
        chk("t2_no_dup_v", 64'(a_v), 64'd0);
        chk("t2_fetch_ua", 64'(a_ua), 64'd0);
        tick();
        chk("t2_uc0_addr", 64'(a_addr), 64'h8000);
        chk("t2_uc0_data", a_data, {16'd0, rom(2'd0)});
        repeat (4) tick();
        chk("t4_uc2_addr", 64'(a_addr), 64'h8002);
        a_rst_n = 1'b0;
        tick();
        chk("t4_rst_v", 64'(a_v), 64'd0);
        chk("t4_rst_addr", 64'(a_addr), 64'd0);
        chk("t4_rst_data", a_data, 64'd0);
        chk("t4_rst_busy", 64'(a_busy), 64'd0);
        chk("t4_rst_ua", 64'(a_ua), 64'd0);
        a_rst_n = 1'b1;
        tick();
        chk("t4_restart_v", 64'(a_v), 64'd1);
        chk("t4_restart_addr", 64'(a_addr), 64'd0);
        chk("t4_restart_data", a_data, 64'd1);
        chk("t4_restart_core", 64'(a_core), 64'd0);
        for (int cyc = 0; cyc < 40 && !a_done; cyc++) tick();
        chk("t4_done", 64'(a_done), 64'd1);
        chk("t4_err", 64'(a_err), 64'd0);
`endif
        b_rst_n = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 2000 && !b_done; cyc++) begin
            tick();
            b_ready = 1'($urandom_range(0, 1));
            if (b_v && b_w && b_ready) begin
                chk_pkt("t6_pkt", n / 8, n % 8, b_w, b_core, b_addr, b_data);
                b_rdata = b_data;
                n++;
            end
        end
        chk("t6_done", 64'(b_done), 64'd1);
        chk("t6_count", 64'(n), 64'd32);
        chk("t6_busy", 64'(b_busy), 64'd0);
        chk("t6_err", 64'(b_err), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
